bilinear_job_ctrl: RTL



---
 rtl/bilinear_job_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bilinear_job_ctrl.sv
// Job queue and launch sequencer for a bilinear scaling core.
// Build option: define DSA_JOB_PERF_EN to add the perf_cycles/perf_pixels counters.
module bilinear_job_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [15:0] job_in_w,
  input  logic [15:0] job_in_h,
  input  logic [15:0] job_out_w,
  input  logic [15:0] job_out_h,
  input  logic [15:0] job_inv_scale_q,
  output logic        core_start,
  output logic [15:0] core_in_w,
  output logic [15:0] core_in_h,
  output logic [15:0] core_out_w,
  output logic [15:0] core_out_h,
  output logic [15:0] core_inv_scale_q,
  input  logic        core_busy,
  input  logic        core_done,
  input  logic        core_wr_valid,
  output logic [4:0]  pending,
  output logic        active,
  output logic        irq,
  input  logic        irq_clr,
  output logic        err,
  input  logic        err_clr,
  output logic [15:0] jobs_done
`ifdef DSA_JOB_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_pixels
`endif
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);

  typedef struct packed {
    logic [15:0] in_w;
    logic [15:0] in_h;
    logic [15:0] out_w;
    logic [15:0] out_h;
    logic [15:0] inv_scale;
  } job_t;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_RUN, S_DONE} state_t;

  state_t        state, state_nx;
  job_t          mem [FIFO_DEPTH];
  job_t          job_new, cfg;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    count;
  logic [1:0]    wait_cnt;
  logic          job_fire, job_bad, job_rej, push, pop, timeout;

  assign job_new  = '{job_in_w, job_in_h, job_out_w, job_out_h, job_inv_scale_q};
  assign job_ready = (count < DEPTH);
  assign job_fire = job_valid & job_ready;
  assign job_bad  = (job_in_w == '0) | (job_in_h == '0) | (job_out_w == '0) | (job_out_h == '0) |
                    (job_out_w > job_in_w) | (job_out_h > job_in_h);
  assign job_rej  = job_fire & job_bad;
  assign push     = job_fire & ~job_bad;
  assign pop      = (state == S_IDLE) & (count != '0) & ~core_busy;

  always_comb begin
    state_nx   = state;
    core_start = 1'b0;
    timeout    = 1'b0;
    case (state)
      S_IDLE:      if (pop) state_nx = S_LAUNCH;
      S_LAUNCH: begin
        core_start = 1'b1;
        state_nx   = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // wait_cnt==3 is the 4th cycle after the start pulse
        if (core_busy) state_nx = S_RUN;
        else if (wait_cnt == 2'd3) begin
          timeout  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_RUN:       if (!core_busy && core_done) state_nx = S_DONE;
      S_DONE:      state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  // Payload storage needs no reset; pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= job_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wait_cnt  <= '0;
      cfg       <= '0;
      irq       <= 1'b0;
      err       <= 1'b0;
      jobs_done <= '0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        cfg    <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: ;
      endcase
      wait_cnt <= (state == S_WAIT_BUSY) ? wait_cnt + 2'd1 : 2'd0;
      irq      <= (state == S_DONE) | (irq & ~irq_clr);
      err      <= job_rej | timeout | (err & ~err_clr);
      if (state == S_DONE) jobs_done <= jobs_done + 16'd1;
    end
  end

`ifdef DSA_JOB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_pixels <= '0;
    end else if (state == S_LAUNCH) begin
      perf_cycles <= 32'd1;
      perf_pixels <= '0;
    end else begin
      if (state inside {S_WAIT_BUSY, S_RUN, S_DONE}) perf_cycles <= perf_cycles + 32'd1;
      if (core_wr_valid && (state inside {S_WAIT_BUSY, S_RUN})) perf_pixels <= perf_pixels + 32'd1;
    end
  end
`endif

  assign core_in_w        = cfg.in_w;
  assign core_in_h        = cfg.in_h;
  assign core_out_w       = cfg.out_w;
  assign core_out_h       = cfg.out_h;
  assign core_inv_scale_q = cfg.inv_scale;
  assign pending          = count;
  assign active           = (state != S_IDLE);
endmodule
